uart_rx_led: RTL

//  8N1 UART receiver for the DE0-Nano top level. Serial input is a GPIO_0 pin

---
 rtl/uart_rx_led.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_led.sv
// uart_rx_led: 8N1 UART receiver with oversampled majority-vote bit decisions.
// Each good byte is strobed on rx_valid and latched onto led_out (LED[7:0]);
// a low stop bit produces a frame_err strobe and discards the byte.
module uart_rx_led #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] led_out
);

  localparam int TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW       = $clog2(OVERSAMPLE);
  localparam int M        = OVERSAMPLE / 2;

  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_LO     = TW'(M - 1);
  localparam logic [TW-1:0] T_MID    = TW'(M);
  localparam logic [TW-1:0] T_HI     = TW'(M + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_nxt;
  logic          sync1, s, s_prev;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          smp_lo, smp_mid;

  logic          tick, decide, wrap, maj;
  logic          edge_start, load_byte, bad_stop;

  // Two-flop synchronizer plus one-cycle history for falling-edge detection
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1  <= 1'b1;
      s      <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      sync1  <= rx_in;
      s      <= sync1;
      s_prev <= s;
    end
  end

  // Tick, decision-point and majority-vote decode
  always_comb begin
    tick       = (div_cnt == DIV_LAST);
    decide     = tick && (tick_cnt == T_HI);
    wrap       = tick && (tick_cnt == T_LAST);
    maj        = (smp_lo & smp_mid) | (smp_lo & s) | (smp_mid & s);
    edge_start = (state == IDLE) && s_prev && !s;
    load_byte  = (state == STOP) && decide && maj;
    bad_stop   = (state == STOP) && decide && !maj;
  end

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (edge_start) state_nxt = START;
      START: begin
        if (decide && maj) state_nxt = IDLE;
        else if (wrap)     state_nxt = DATA;
      end
      DATA:  if (wrap && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:  if (decide) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Tick divider, in-bit tick counter, vote samples and shift register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      smp_lo   <= 1'b0;
      smp_mid  <= 1'b0;
    end else begin
      // Realigning the divider on the start edge puts the first tick
      // TICK_DIV clocks after the edge, so bit sampling is phase-locked to it.
      if (edge_start || tick) div_cnt <= '0;
      else                    div_cnt <= div_cnt + 1'b1;

      if (edge_start)
        tick_cnt <= '0;
      else if (tick && (state != IDLE))
        tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;

      if (tick && (tick_cnt == T_LO))  smp_lo  <= s;
      if (tick && (tick_cnt == T_MID)) smp_mid <= s;

      if ((state == START) && wrap)
        bit_idx <= '0;
      else if ((state == DATA) && wrap)
        bit_idx <= bit_idx + 1'b1;

      if ((state == DATA) && decide)
        shreg <= {maj, shreg[7:1]};
    end
  end

  // Output strobes and byte/LED registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_data   <= '0;
      led_out   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load_byte;
      frame_err <= bad_stop;
      if (load_byte) begin
        rx_data <= shreg;
        led_out <= shreg;
      end
    end
  end

endmodule
